aes_ahb_regif: RTL

//  Parametrised AHB-Lite slave register interface for the AES core: key, data-in, data-out, control and status.

---
 rtl/aes_regif_pkg.sv | 31 +++
 rtl/aes_ahb_regif_if.sv | 28 ++
 rtl/aes_ahb_dphase.sv | 75 +++++++
 rtl/aes_ahb_regif.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/aes_regif_pkg.sv
// AES AHB register interface: shared constants and types.
// Bus encodings, register map pages/words, STATUS bits, FSM states.
package aes_regif_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Register map: offset[11:8] selects a page,
  // offset[7:2] selects the word within it.
  localparam logic [3:0] PG_CTRL = 4'h0;
  localparam logic [3:0] PG_KEY  = 4'h1;
  localparam logic [3:0] PG_DIN  = 4'h2;
  localparam logic [3:0] PG_DOUT = 4'h3;
  localparam logic [5:0] WD_CTRL = 6'd0;
  localparam logic [5:0] WD_STAT = 6'd1;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_XFER,
    DP_WAIT,
    DP_ERR1,
    DP_ERR2
  } dp_state_e;

endpackage

// File: rtl/aes_ahb_regif_if.sv
// AHB-Lite slave-side bus bundle for the AES register interface.
// master drives request + hready; slave drives hreadyout/hresp/hrdata.
interface aes_ahb_if #(
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite,
    output hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite,
    input  hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/aes_ahb_dphase.sv
// Data-phase FSM: ready/response sequencing, write commit strobe.
// in: accept/err of new addr phase, registered write, stall target,
// core busy. out: hreadyout, hresp, commit, read enable, err set.
module aes_ahb_dphase
  import aes_regif_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic accept_i,
  input  logic err_i,
  input  logic write_i,
  input  logic stall_tgt_i,
  input  logic core_busy_i,
  output logic hreadyout_o,
  output logic hresp_o,
  output logic commit_o,
  output logic rd_en_o,
  output logic err_set_o
);

  dp_state_e state_q, state_d, nxt_s;

  // State entered when this cycle ends a data phase.
  assign nxt_s = accept_i
               ? (err_i ? DP_ERR1 : DP_XFER)
               : DP_IDLE;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DP_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    commit_o    = 1'b0;
    rd_en_o     = 1'b0;
    err_set_o   = 1'b0;
    unique case (state_q)
      DP_IDLE: state_d = nxt_s;
      DP_XFER: begin
        if (write_i && stall_tgt_i
            && core_busy_i) begin
          hreadyout_o = 1'b0;
          state_d     = DP_WAIT;
        end else begin
          commit_o = write_i;
          rd_en_o  = !write_i;
          state_d  = nxt_s;
        end
      end
      DP_WAIT: begin
        if (core_busy_i) begin
          hreadyout_o = 1'b0;
        end else begin
          commit_o = 1'b1;
          state_d  = nxt_s;
        end
      end
      DP_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
        err_set_o   = 1'b1;
        state_d     = DP_ERR2;
      end
      DP_ERR2: begin
        hresp_o = 1'b1;
        state_d = nxt_s;
      end
      default: state_d = DP_IDLE;
    endcase
  end

endmodule

// File: rtl/aes_ahb_regif.sv
// AHB-Lite register interface for the AES core (CTRL/STATUS/KEY/DIN/DOUT).
// Ports: hclk, hreset, ahb (slave), key_o, din_o, mode_o, start_o,
// core_busy_i, core_done_i, dout_i.
module aes_ahb_regif
  import aes_regif_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int BLK_WORDS = 4,
  parameter int ADDR_W    = 12
) (
  input  logic                   hclk,
  input  logic                   hreset,
  aes_ahb_if.slave               ahb,
  output logic [32*KEY_WORDS-1:0] key_o,
  output logic [32*BLK_WORDS-1:0] din_o,
  output logic                   mode_o,
  output logic                   start_o,
  input  logic                   core_busy_i,
  input  logic                   core_done_i,
  input  logic [32*BLK_WORDS-1:0] dout_i
);

  localparam int KI_W = $clog2(KEY_WORDS);
  localparam int BI_W = $clog2(BLK_WORDS);

  logic [KEY_WORDS-1:0][31:0] key_q;
  logic [BLK_WORDS-1:0][31:0] din_q;
  logic [BLK_WORDS-1:0][31:0] dout_q;
  logic mode_q, start_q, done_q, err_q;

  logic [3:0] a_pg, pg_q;
  logic [5:0] a_wd, wd_q;
  logic       wr_q;
  logic accept, a_map, a_err;
  logic commit, rd_en, err_set, stall_tgt;
  logic wr_ctrl, wr_stat, wr_key, wr_din;
  logic done_clr;
  logic [2:0] status;
  logic [DATA_W-1:0] rd_mux;
  logic unused_ok;

  assign unused_ok = ^{ahb.haddr[31:ADDR_W],
                       ahb.htrans[0]};

  assign a_pg   = ahb.haddr[11:8];
  assign a_wd   = ahb.haddr[7:2];
  assign accept = ahb.hsel & ahb.hready
                & ahb.htrans[1];

  always_comb begin
    a_map = 1'b0;
    case (a_pg)
      PG_CTRL: a_map = a_wd <= WD_STAT;
      PG_KEY:  a_map = a_wd < 6'(KEY_WORDS);
      PG_DIN:  a_map = a_wd < 6'(BLK_WORDS);
      PG_DOUT: a_map = (a_wd < 6'(BLK_WORDS))
                     && !ahb.hwrite;
      default: a_map = 1'b0;
    endcase
  end

  assign a_err = !a_map
              || ahb.hsize != HSIZE_WORD
              || ahb.haddr[1:0] != 2'b00;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      pg_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
    end else if (accept) begin
      pg_q <= a_pg;
      wd_q <= a_wd;
      wr_q <= ahb.hwrite;
    end
  end

  // Registers the core reads while running must not change under it.
  assign stall_tgt = pg_q == PG_KEY
                  || pg_q == PG_DIN
                  || (pg_q == PG_CTRL
                      && wd_q == WD_CTRL);

  aes_ahb_dphase u_dphase (
    .clk_i       (hclk),
    .rst_i       (hreset),
    .accept_i    (accept),
    .err_i       (a_err),
    .write_i     (wr_q),
    .stall_tgt_i (stall_tgt),
    .core_busy_i (core_busy_i),
    .hreadyout_o (ahb.hreadyout),
    .hresp_o     (ahb.hresp),
    .commit_o    (commit),
    .rd_en_o     (rd_en),
    .err_set_o   (err_set)
  );

  assign wr_ctrl = commit && pg_q == PG_CTRL
                && wd_q == WD_CTRL;
  assign wr_stat = commit && pg_q == PG_CTRL
                && wd_q == WD_STAT;
  assign wr_key  = commit && pg_q == PG_KEY;
  assign wr_din  = commit && pg_q == PG_DIN;

  // A start clears done so software can poll for the new result.
  assign done_clr = (wr_ctrl && ahb.hwdata[0])
                 || (wr_stat && ahb.hwdata[ST_DONE]);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      key_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= wr_ctrl && ahb.hwdata[0];
      if (wr_ctrl)
        mode_q <= ahb.hwdata[1];
      if (wr_key)
        key_q[wd_q[KI_W-1:0]] <= ahb.hwdata;
      if (wr_din)
        din_q[wd_q[BI_W-1:0]] <= ahb.hwdata;
      if (core_done_i)
        dout_q <= dout_i;
      if (core_done_i)   done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
      if (err_set)
        err_q <= 1'b1;
      else if (wr_stat && ahb.hwdata[ST_ERR])
        err_q <= 1'b0;
    end
  end

  // busy covers the gap between start and the core raising busy.
  assign status = {err_q, done_q,
                   core_busy_i | start_q};

  always_comb begin
    rd_mux = '0;
    case (pg_q)
      PG_CTRL: begin
        if (wd_q == WD_CTRL) rd_mux[1]   = mode_q;
        else                 rd_mux[2:0] = status;
      end
      PG_KEY:  rd_mux = key_q[wd_q[KI_W-1:0]];
      PG_DIN:  rd_mux = din_q[wd_q[BI_W-1:0]];
      PG_DOUT: rd_mux = dout_q[wd_q[BI_W-1:0]];
      default: rd_mux = '0;
    endcase
  end

  assign ahb.hrdata = rd_en ? rd_mux : '0;

  assign key_o   = key_q;
  assign din_o   = din_q;
  assign mode_o  = mode_q;
  assign start_o = start_q;

endmodule
